// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: pipelined DVI TMDS 8b/10b encoder for one colour channel.
// Four register levels between input and the tmds port:
//   s1  input capture plus popcount of the data byte
//   s2  transition-minimised word q_m plus its ones/zeros counts
//   s3  disparity control, running disparity r_cnt
//   out registered symbol that drives the serializer
// Optional build macro: TMDS_TERC4_EN adds island/aux_in and TERC4 coding
// of data-island guard periods. Without it the block is pure DVI.
module tmds_encoder_pipe (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data_in,
  input  logic [1:0] ctrl_in,
`ifdef TMDS_TERC4_EN
  input  logic       island,
  input  logic [3:0] aux_in,
`endif
  output logic [9:0] tmds
);

  localparam logic [9:0] CTRL_IDLE = 10'b1101010100;

  // stage 1 registers
  logic       r_s1_de;
  logic [1:0] r_s1_ctrl;
  logic [7:0] r_s1_data;
  logic [3:0] r_s1_n1d;
  // stage 2 registers
  logic       r_s2_de;
  logic [1:0] r_s2_ctrl;
  logic [8:0] r_s2_qm;
  logic [3:0] r_s2_n1q;
  logic [3:0] r_s2_n0q;
  // stage 3 and output registers
  logic signed [5:0] r_cnt;
  logic [9:0]        r_tmds_s3;
  logic [9:0]        r_tmds;

`ifdef TMDS_TERC4_EN
  logic       r_s1_island;
  logic [3:0] r_s1_aux;
  logic       r_s2_island;
  logic [3:0] r_s2_aux;
`endif

  logic [3:0]        w_n1d;
  logic              w_use_xnor;
  logic [8:0]        w_qm;
  logic [3:0]        w_n1q;
  logic [9:0]        w_sym;
  logic signed [5:0] w_cnt_nxt;
  logic signed [5:0] w_n1q_s;
  logic signed [5:0] w_n0q_s;
  logic signed [5:0] w_q8x2;
  logic signed [5:0] w_nq8x2;

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    logic [9:0] c;
    case (a)
      4'h0: c = 10'b1010011100;
      4'h1: c = 10'b1001100011;
      4'h2: c = 10'b1011100100;
      4'h3: c = 10'b1011100010;
      4'h4: c = 10'b0101110001;
      4'h5: c = 10'b0100011110;
      4'h6: c = 10'b0110001110;
      4'h7: c = 10'b0100111100;
      4'h8: c = 10'b1011001100;
      4'h9: c = 10'b0100111001;
      4'hA: c = 10'b0110011100;
      4'hB: c = 10'b1011000110;
      4'hC: c = 10'b1010001110;
      4'hD: c = 10'b1001110001;
      4'hE: c = 10'b0101100011;
      default: c = 10'b1011000011;
    endcase
    return c;
  endfunction
`endif

  // ones count of the live input byte, captured in stage 1
  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, data_in[i]};
  end

  // stage 1: capture pixel, control and its popcount
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_s1_de   <= 1'b0;
      r_s1_ctrl <= 2'b00;
      r_s1_data <= 8'h00;
      r_s1_n1d  <= 4'd0;
`ifdef TMDS_TERC4_EN
      r_s1_island <= 1'b0;
      r_s1_aux    <= 4'h0;
`endif
    end else begin
      r_s1_de   <= de;
      r_s1_ctrl <= ctrl_in;
      r_s1_data <= data_in;
      r_s1_n1d  <= w_n1d;
`ifdef TMDS_TERC4_EN
      r_s1_island <= island;
      r_s1_aux    <= aux_in;
`endif
    end
  end

  // transition-minimising XOR/XNOR chain and its ones count
  always_comb begin
    w_use_xnor = (r_s1_n1d > 4'd4) || ((r_s1_n1d == 4'd4) && !r_s1_data[0]);
    w_qm       = '0;
    w_qm[0]    = r_s1_data[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_s1_data[i]) : (w_qm[i-1] ^ r_s1_data[i]);
    w_qm[8] = ~w_use_xnor;
    w_n1q   = '0;
    for (int i = 0; i < 8; i++) w_n1q = w_n1q + {3'b000, w_qm[i]};
  end

  // stage 2: register q_m and its balance counts
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_s2_de   <= 1'b0;
      r_s2_ctrl <= 2'b00;
      r_s2_qm   <= 9'd0;
      r_s2_n1q  <= 4'd0;
      r_s2_n0q  <= 4'd8;
`ifdef TMDS_TERC4_EN
      r_s2_island <= 1'b0;
      r_s2_aux    <= 4'h0;
`endif
    end else begin
      r_s2_de   <= r_s1_de;
      r_s2_ctrl <= r_s1_ctrl;
      r_s2_qm   <= w_qm;
      r_s2_n1q  <= w_n1q;
      r_s2_n0q  <= 4'd8 - w_n1q;
`ifdef TMDS_TERC4_EN
      r_s2_island <= r_s1_island;
      r_s2_aux    <= r_s1_aux;
`endif
    end
  end

  // disparity control: pick inverted/plain q_m and update running disparity
  always_comb begin
    w_n1q_s   = $signed({2'b00, r_s2_n1q});
    w_n0q_s   = $signed({2'b00, r_s2_n0q});
    w_q8x2    = $signed({4'b0000, r_s2_qm[8], 1'b0});
    w_nq8x2   = $signed({4'b0000, ~r_s2_qm[8], 1'b0});
    w_sym     = CTRL_IDLE;
    w_cnt_nxt = r_cnt;
    if (!r_s2_de) begin
      case (r_s2_ctrl)
        2'b00:   w_sym = 10'b1101010100;
        2'b01:   w_sym = 10'b0010101011;
        2'b10:   w_sym = 10'b0101010100;
        default: w_sym = 10'b1010101011;
      endcase
`ifdef TMDS_TERC4_EN
      if (r_s2_island) w_sym = terc4_code(r_s2_aux);
`endif
      w_cnt_nxt = 6'sd0;
    end else if ((r_cnt == 6'sd0) || (r_s2_n1q == r_s2_n0q)) begin
      w_sym = {~r_s2_qm[8], r_s2_qm[8], r_s2_qm[8] ? r_s2_qm[7:0] : ~r_s2_qm[7:0]};
      w_cnt_nxt = r_s2_qm[8] ? (r_cnt + w_n1q_s - w_n0q_s) : (r_cnt + w_n0q_s - w_n1q_s);
    end else if (((r_cnt > 6'sd0) && (r_s2_n1q > r_s2_n0q)) ||
                 ((r_cnt < 6'sd0) && (r_s2_n0q > r_s2_n1q))) begin
      w_sym     = {1'b1, r_s2_qm[8], ~r_s2_qm[7:0]};
      w_cnt_nxt = r_cnt + w_q8x2 + w_n0q_s - w_n1q_s;
    end else begin
      w_sym     = {1'b0, r_s2_qm[8], r_s2_qm[7:0]};
      w_cnt_nxt = r_cnt - w_nq8x2 + w_n1q_s - w_n0q_s;
    end
  end

  // stage 3 and output register; reset drops in-flight symbols and disparity
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_cnt     <= 6'sd0;
      r_tmds_s3 <= CTRL_IDLE;
      r_tmds    <= CTRL_IDLE;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tmds_s3 <= w_sym;
      r_tmds    <= r_tmds_s3;
    end
  end

  assign tmds = r_tmds;

endmodule

// File: doc/tmds_encoder_pipe.md
# tmds_encoder_pipe

Pipelined DVI TMDS 8b/10b encoder for one channel, sitting between the pixel colour logic and the 10:1 serializer inside the DVI output path. Three instances, one per colour channel, take 8-bit colour, data enable and 2-bit control. Each produces a DC-balanced, transition-minimised 10-bit symbol every pixel clock. The output is registered, so the serializer can be clocked directly from it at 148.5 MHz.

## Interface
- No parameters.
- clk_pix  input  1  pixel clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- de  input  1  data enable: 1 = encode data_in, 0 = encode ctrl_in
- data_in  input  8  pixel colour component
- ctrl_in  input  2  control bits ({vsync, hsync} on ch0, 2'b00 otherwise)
- tmds  output  10  encoded symbol; bit 0 is transmitted first

## Operation
- Stage 1 registers de, ctrl_in and data_in, and computes n1d = popcount(data_in) (4 bits).
- Stage 2 builds the 9-bit intermediate word q_m:
  - Use XNOR if n1d > 4, or if n1d == 4 and d[0] == 0. Otherwise use XOR.
  - q_m[0] = d[0].
  - q_m[i] = q_m[i-1] XOR/XNOR d[i].
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m, n1q = popcount(q_m[7:0]) and n0q = 8 - n1q.
- Stage 3 applies disparity control. cnt is a 6-bit signed running disparity.
  - If de == 0:
    - tmds is set from ctrl: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
    - cnt is set to 0.
  - Else if cnt == 0 or n1q == n0q:
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q - n0q) : (n0q - n1q).
  - Else if (cnt > 0 and n1q > n0q) or (cnt < 0 and n0q > n1q):
    - tmds = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + n0q - n1q.
  - Else:
    - tmds = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + n1q - n0q.
- Arithmetic is signed 6-bit throughout, with counts zero-extended before subtraction. cnt stays within ±10 by construction, so no saturation logic is needed.
- de and ctrl travel through the pipeline alongside the data. Each stage uses its own delayed copy, never the live input.
- A de change takes effect on the symbol of that same pixel. There is no leakage between pixels.

## Timing
- Latency is 3 cycles: inputs sampled at edge N appear on tmds after edge N+3.
- Throughput is one symbol per clock, with no stalls and no handshake.
- Reset is synchronous. At any edge with rst=1, all pipeline de and ctrl registers clear to 0, cnt is set to 0, and tmds is set to 10'b1101010100.
- After rst falls, tmds holds 10'b1101010100 until input from the first post-reset edge reaches the output, three cycles later.
- rst asserted mid-frame discards all in-flight pixels. The disparity history is lost, and cnt restarts from 0.

## Configuration
- TMDS_TERC4_EN adds ports island (input 1) and aux_in (input 4), both pipelined with de.
- With TMDS_TERC4_EN defined, when stage 3 sees island=1 and de=0:
  - tmds is the TERC4 code for aux: 0:1010011100, 1:1001100011, 2:1011100100, 3:1011100010, 4:0101110001, 5:0100011110, 6:0110001110, 7:0100111100, 8:1011001100, 9:0100111001, A:0110011100, B:1011000110, C:1010001110, D:1001110001, E:0101100011, F:1011000011.
  - cnt is set to 0.
  - de=1 takes priority over island.
- Without TMDS_TERC4_EN, these ports do not exist and behaviour is pure DVI as above.

## Test plan
- Reset: hold rst for 2 cycles, then de=0, ctrl=00 -> tmds = 0x354 throughout reset and after it.
- Control codes: de=0 with ctrl = 00/01/10/11 on consecutive cycles -> tmds = 0x354/0x0AB/0x154/0x2AB, starting 3 cycles later, one per cycle.
- DC balance: de=1, data=0x00 continuously from cnt=0 -> 0x100, 0x3FF, 0x100, 0x3FF…; internal cnt = -8, 2, -6, 4, -4, 6…
- XNOR path: de=1, data=0xFF from cnt=0 -> first symbol 0x200, cnt=-8.
- Disparity reset: data=0x00 with de=1, then one de=0 cycle, then 0x00 with de=1 -> symbols 0x100, 0x354, 0x100 (cnt restarted).
- Mid-stream reset: rst pulsed for 1 cycle during the 0x00 stream -> tmds = 0x354 on the following edge, and the sequence restarts with 0x100. With TMDS_TERC4_EN: island=1, aux=0x5, de=0 -> tmds = 10'b0100011110.
